piso_serializer: RTL and testbench

Parallel-in/serial-out transmitter. It captures a WIDTH-bit word through a valid/ready handshake and drives it one bit per enabled clock on a serial line, with a frame-start marker and a completion pulse. It is the sending end for the team's serial-in shift-register receiver: its `sout` drives the receiver's serial input, clocked from the same `clk`. Words can be sent back to back with no idle cycle between frames.

---
 rtl/piso_serializer.sv | 100 ++++++++++
 tb/tb_piso_serializer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out transmitter with valid/ready capture
//
// Captures a WIDTH-bit word on a din_valid/din_ready handshake and shifts it
// out one bit per enabled clock. Frames may follow each other with no gap:
// the next word is taken on the edge that consumes the last bit.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   din         parallel word, sampled only on a handshake
//   din_valid   producer has a word
//   din_ready   block can accept a word this cycle (combinational)
//   en          shift enable; 0 stalls the serial side
//   sout        serial data bit (0 when idle)
//   sout_valid  sout carries a frame bit
//   frame_start first bit of a frame is on sout
//   done        one-cycle pulse after the last bit of a frame is consumed
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic             state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic in_shift;
  logic last_bit;
  logic consume;
  logic accept;
  logic out_bit;

  assign in_shift = (state_q == ST_SHIFT);
  assign last_bit = (cnt_q == LAST_IDX);
  assign consume  = in_shift && en;
  // rst is folded in so ready reads 0 while the block is held in reset.
  assign din_ready = rst && (!in_shift || (last_bit && en));
  assign accept    = din_valid && din_ready;

  assign out_bit = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

  // sreg keeps shifted leftovers after a frame, so gate sout with the state.
  assign sout        = in_shift ? out_bit : 1'b0;
  assign sout_valid  = in_shift;
  assign frame_start = in_shift && (cnt_q == '0);
  assign done        = done_q;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = consume && last_bit;
    if (accept) begin
      // Covers both a fresh start from idle and a reload on the last-bit edge.
      state_d = ST_SHIFT;
      sreg_d  = din;
      cnt_d   = '0;
    end else if (consume) begin
      if (last_bit) begin
        state_d = ST_IDLE;
      end else begin
        sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer (MSB-first and LSB-first)
module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic first;
    logic last;
  } entry_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] din_a       [2];
  logic       din_valid_a [2];
  logic       din_ready_a [2];
  logic       sout_a      [2];
  logic       sv_a        [2];
  logic       fs_a        [2];
  logic       done_a      [2];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din_a[0]), .din_valid(din_valid_a[0]),
    .din_ready(din_ready_a[0]), .en(en), .sout(sout_a[0]), .sout_valid(sv_a[0]),
    .frame_start(fs_a[0]), .done(done_a[0])
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din_a[1]), .din_valid(din_valid_a[1]),
    .din_ready(din_ready_a[1]), .en(en), .sout(sout_a[1]), .sout_valid(sv_a[1]),
    .frame_start(fs_a[1]), .done(done_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance scoreboard: bits pushed on accept, compared every negedge,
  // popped when the coming edge consumes them.
  for (genvar g = 0; g < 2; g++) begin : mon
    entry_t q[$];
    logic   pend;
    entry_t f;
    logic   ev;
    logic   er;
    int     idx;
    string  pfx;

    initial pend = 1'b0;

    always @(negedge clk) begin
      pfx = (g == 0) ? "m_" : "l_";
      if (!rst) begin
        q.delete();
        pend = 1'b0;
      end
      ev = (q.size() != 0);
      f  = '0;
      if (ev) f = q[0];
      er = rst && (!ev || (f.last && en));
      chk({pfx, "sout"},        sout_a[g],      ev ? f.b : 1'b0);
      chk({pfx, "sout_valid"},  sv_a[g],        ev);
      chk({pfx, "frame_start"}, fs_a[g],        ev && f.first);
      chk({pfx, "done"},        done_a[g],      pend);
      chk({pfx, "din_ready"},   din_ready_a[g], er);
      pend = 1'b0;
      if (ev && en) begin
        pend = f.last;
        void'(q.pop_front());
      end
      if (din_valid_a[g] && er) begin
        for (int i = 0; i < 4; i++) begin
          idx = (g == 0) ? 3 - i : i;
          q.push_back({din_a[g][idx], i == 0, i == 3});
        end
      end
    end
  end

  task automatic send(input int g, input logic [3:0] w, input bit keep);
    int n;
    n = 0;
    din_a[g]       = w;
    din_valid_a[g] = 1'b1;
    @(negedge clk);
    while (!din_ready_a[g] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", din_ready_a[g], 1'b1);
    @(posedge clk);
    #1;
    if (!keep) din_valid_a[g] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din_a[i]       = '0;
      din_valid_a[i] = 1'b0;
    end

    // Reset sequence
    #50;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    // Single frame MSB-first
    send(0, 4'b1010, 1'b0);
    idle(6);

    // Back-to-back frames
    send(0, 4'b1100, 1'b1);
    send(0, 4'b0011, 1'b0);
    idle(6);

    // Stall after the second bit appears
    send(0, 4'b1001, 1'b0);
    idle(1);
    en = 1'b0;
    idle(3);
    en = 1'b1;
    idle(6);

    // LSB-first instance
    send(1, 4'b0001, 1'b0);
    idle(6);

    // Reset during the third bit
    send(0, 4'b1111, 1'b0);
    idle(2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_sout",       sout_a[0],      1'b0);
    chk("async_sout_valid", sv_a[0],        1'b0);
    chk("async_din_ready",  din_ready_a[0], 1'b0);
    idle(2);
    rst = 1'b1;
    idle(1);
    send(0, 4'b0110, 1'b0);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
